// File: rtl/vram_cpu_port_pkg.sv
// Shared types and constants for the CPU-side VRAM access port.
// Holds the access FSM encoding, control-byte opcodes and address helpers.
package vram_cpu_port_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;
    localparam int REG_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_PEND = 2'd1,
        ST_RD_PEND = 2'd2,
        ST_RD_WAIT = 2'd3
    } state_t;

    // Opcode carried in bits [7:6] of the second control byte
    localparam logic [1:0] CC_RD_SETUP = 2'b00;
    localparam logic [1:0] CC_WR_SETUP = 2'b01;
    localparam logic [1:0] CC_REG_WR   = 2'b10;
    localparam logic [1:0] CC_NOP      = 2'b11;

    function automatic logic [ADDR_W-1:0] setup_addr(
        input logic [1:0]        page,
        input logic [5:0]        mid,
        input logic [DATA_W-1:0] lo
    );
        return {page, mid, lo};
    endfunction

    // Natural 16-bit wrap from 0xFFFF to 0x0000
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + 16'd1;
    endfunction

endpackage

// File: rtl/vram_cpu_port.sv
// CPU access port into VRAM: two-byte control protocol, read-ahead data port,
// and a small FSM that waits for the arbiter slot before strobing the RAM.
module vram_cpu_port
    import vram_cpu_port_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic              cpu_mode,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              busy,
    output logic              ovr,
    input  logic [1:0]        addr_hi,
    input  logic [DATA_W-1:0] status_in,
    output logic              status_rd,
    output logic              reg_we,
    output logic [REG_W-1:0]  reg_addr,
    output logic [DATA_W-1:0] reg_data,
    input  logic              vram_gnt,
    output logic              vram_we,
    output logic              vram_re,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_dout,
    input  logic [DATA_W-1:0] vram_din
);

    state_t              state;
    logic                ff;
    logic [DATA_W-1:0]   lo_byte;
    logic [DATA_W-1:0]   rd_buf;
    logic [DATA_W-1:0]   wr_buf;
    logic [ADDR_W-1:0]   addr;
    logic                accept;

    assign busy   = (state != ST_IDLE);
    assign accept = cpu_req && !busy;

    // RAM strobes only ever come from mutually exclusive states
    assign vram_we   = (state == ST_WR_PEND) && vram_gnt;
    assign vram_re   = (state == ST_RD_PEND) && vram_gnt;
    assign vram_addr = addr;
    assign vram_dout = wr_buf;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ff        <= 1'b0;
            ovr       <= 1'b0;
            addr      <= '0;
            lo_byte   <= '0;
            rd_buf    <= '0;
            wr_buf    <= '0;
            cpu_dout  <= '0;
            reg_we    <= 1'b0;
            status_rd <= 1'b0;
            reg_addr  <= '0;
            reg_data  <= '0;
        end else begin
            reg_we    <= 1'b0;
            status_rd <= 1'b0;

            if (cpu_req && busy)
                ovr <= 1'b1;

            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (cpu_mode) begin
                            if (cpu_wr) begin
                                if (!ff) begin
                                    lo_byte <= cpu_din;
                                    ff      <= 1'b1;
                                end else begin
                                    ff <= 1'b0;
                                    case (cpu_din[7:6])
                                        CC_RD_SETUP: begin
                                            addr  <= setup_addr(addr_hi, cpu_din[5:0], lo_byte);
                                            state <= ST_RD_PEND;
                                        end
                                        CC_WR_SETUP: begin
                                            addr <= setup_addr(addr_hi, cpu_din[5:0], lo_byte);
                                        end
                                        CC_REG_WR: begin
                                            reg_we   <= 1'b1;
                                            reg_addr <= cpu_din[5:0];
                                            reg_data <= lo_byte;
                                        end
                                        default: ;
                                    endcase
                                end
                            end else begin
                                cpu_dout  <= status_in;
                                status_rd <= 1'b1;
                                ff        <= 1'b0;
                            end
                        end else begin
                            // Data port: writes also refresh the read-ahead buffer
                            ff <= 1'b0;
                            if (cpu_wr) begin
                                rd_buf <= cpu_din;
                                wr_buf <= cpu_din;
                                state  <= ST_WR_PEND;
                            end else begin
                                cpu_dout <= rd_buf;
                                state    <= ST_RD_PEND;
                            end
                        end
                    end
                end
                ST_WR_PEND: begin
                    if (vram_gnt) begin
                        addr  <= addr_inc(addr);
                        state <= ST_IDLE;
                    end
                end
                ST_RD_PEND: begin
                    if (vram_gnt)
                        state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    // RAM data is valid the cycle after the granted read
                    rd_buf <= vram_din;
                    addr   <= addr_inc(addr);
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_cpu_port.sv
// Directed bench for vram_cpu_port with a behavioural single-port RAM.
module tb_vram_cpu_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_wr, cpu_mode;
    logic [7:0]  cpu_din, cpu_dout;
    logic        busy, ovr;
    logic [1:0]  addr_hi;
    logic [7:0]  status_in;
    logic        status_rd, reg_we;
    logic [5:0]  reg_addr;
    logic [7:0]  reg_data;
    logic        vram_gnt, vram_we, vram_re;
    logic [15:0] vram_addr;
    logic [7:0]  vram_dout, vram_din;

    int tests = 0;
    int fails = 0;
    int overlap = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    logic [15:0] rd_addr_q[$];

    vram_cpu_port dut (
        .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_wr(cpu_wr),
        .cpu_mode(cpu_mode), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .busy(busy), .ovr(ovr), .addr_hi(addr_hi), .status_in(status_in),
        .status_rd(status_rd), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_data(reg_data), .vram_gnt(vram_gnt), .vram_we(vram_we),
        .vram_re(vram_re), .vram_addr(vram_addr), .vram_dout(vram_dout),
        .vram_din(vram_din)
    );

    always #5 clk = ~clk;

    // Single-port RAM, registered read, plus a strobe log
    always @(posedge clk) begin
        if (vram_we && vram_re) overlap++;
        if (vram_we) begin
            mem[vram_addr] <= vram_dout;
            wr_addr_q.push_back(vram_addr);
            wr_data_q.push_back(vram_dout);
        end
        if (vram_re) begin
            vram_din <= mem[vram_addr];
            rd_addr_q.push_back(vram_addr);
        end
    end

    typedef struct {
        logic       req, wr, mode;
        logic [7:0] din;
        logic       gnt;
        logic       busy, we, re, rwe, srd;
        logic [15:0] addr;
        logic [7:0] dout, cdout;
        logic [5:0] ra;
        logic [7:0] rd;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic op(input logic wr, input logic mode, input logic [7:0] din);
        cpu_req = 1'b1; cpu_wr = wr; cpu_mode = mode; cpu_din = din;
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bit stayed_busy;
        int nwr;
        logic [50:0] act, exp;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0100] = 8'h11;
        mem[16'h0101] = 8'h22;
        mem[16'h0200] = 8'h77;
        vram_din  = 8'h00;
        reset     = 1'b1;
        cpu_req   = 1'b0; cpu_wr = 1'b0; cpu_mode = 1'b0; cpu_din = 8'h00;
        addr_hi   = 2'd0;
        status_in = 8'h5A;
        vram_gnt  = 1'b1;

        //          req wr md din   g  bsy we re rwe srd addr      dout   cdout  ra    rd
        tbl[0]  = '{1, 1, 1, 8'h34, 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 8'h00, 6'd0, 8'h00};
        tbl[1]  = '{1, 1, 1, 8'h52, 1, 0, 0, 0, 0, 0, 16'h1234, 8'h00, 8'h00, 6'd0, 8'h00};
        tbl[2]  = '{1, 1, 0, 8'hA5, 1, 1, 1, 0, 0, 0, 16'h1234, 8'hA5, 8'h00, 6'd0, 8'h00};
        tbl[3]  = '{0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 16'h1235, 8'hA5, 8'h00, 6'd0, 8'h00};
        tbl[4]  = '{1, 1, 1, 8'h07, 1, 0, 0, 0, 0, 0, 16'h1235, 8'hA5, 8'h00, 6'd0, 8'h00};
        tbl[5]  = '{1, 1, 1, 8'h87, 1, 0, 0, 0, 1, 0, 16'h1235, 8'hA5, 8'h00, 6'd7, 8'h07};
        tbl[6]  = '{0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 16'h1235, 8'hA5, 8'h00, 6'd7, 8'h07};
        tbl[7]  = '{1, 0, 1, 8'h00, 1, 0, 0, 0, 0, 1, 16'h1235, 8'hA5, 8'h5A, 6'd7, 8'h07};
        tbl[8]  = '{0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 16'h1235, 8'hA5, 8'h5A, 6'd7, 8'h07};
        tbl[9]  = '{1, 1, 1, 8'h00, 1, 0, 0, 0, 0, 0, 16'h1235, 8'hA5, 8'h5A, 6'd7, 8'h07};
        tbl[10] = '{1, 1, 1, 8'h01, 1, 1, 0, 1, 0, 0, 16'h0100, 8'hA5, 8'h5A, 6'd7, 8'h07};
        tbl[11] = '{0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 16'h0100, 8'hA5, 8'h5A, 6'd7, 8'h07};
        tbl[12] = '{0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 16'h0101, 8'hA5, 8'h5A, 6'd7, 8'h07};
        tbl[13] = '{1, 0, 0, 8'h00, 1, 1, 0, 1, 0, 0, 16'h0101, 8'hA5, 8'h11, 6'd7, 8'h07};
        tbl[14] = '{0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 16'h0101, 8'hA5, 8'h11, 6'd7, 8'h07};
        tbl[15] = '{0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 16'h0102, 8'hA5, 8'h11, 6'd7, 8'h07};
        tbl[16] = '{1, 0, 0, 8'h00, 1, 1, 0, 1, 0, 0, 16'h0102, 8'hA5, 8'h22, 6'd7, 8'h07};
        tbl[17] = '{0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 16'h0102, 8'hA5, 8'h22, 6'd7, 8'h07};
        tbl[18] = '{0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 16'h0103, 8'hA5, 8'h22, 6'd7, 8'h07};

        idle(2);
        reset = 1'b0;
        chk("reset_state", {busy, ovr, vram_we, vram_re, reg_we, status_rd, vram_addr, cpu_dout, reg_addr, reg_data},
            {6'b0, 16'h0000, 8'h00, 6'd0, 8'h00});

        for (int i = 0; i < 19; i++) begin
            cpu_req = tbl[i].req; cpu_wr = tbl[i].wr; cpu_mode = tbl[i].mode;
            cpu_din = tbl[i].din; vram_gnt = tbl[i].gnt;
            @(posedge clk); #1;
            act = {busy, vram_we, vram_re, reg_we, status_rd, vram_addr, vram_dout, cpu_dout, reg_addr, reg_data};
            exp = {tbl[i].busy, tbl[i].we, tbl[i].re, tbl[i].rwe, tbl[i].srd, tbl[i].addr,
                   tbl[i].dout, tbl[i].cdout, tbl[i].ra, tbl[i].rd};
            chk($sformatf("vec%0d", i), 64'(act), 64'(exp));
            cpu_req = 1'b0;
        end
        chk("write_log_count", 64'(wr_addr_q.size()), 64'd1);
        chk("write_log_entry", {wr_addr_q[0], wr_data_q[0]}, {16'h1234, 8'hA5});
        chk("read_log_count", 64'(rd_addr_q.size()), 64'd3);
        chk("read_log_addrs", {rd_addr_q[0], rd_addr_q[1], rd_addr_q[2]}, {16'h0100, 16'h0101, 16'h0102});

        // Grant starvation with a dropped request in the middle
        op(1, 1, 8'h00);
        op(1, 1, 8'h50);
        vram_gnt = 1'b0;
        nwr = wr_addr_q.size();
        op(1, 0, 8'h3C);
        stayed_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) op(1, 0, 8'h99);
            else idle(1);
            if (!busy || vram_we) stayed_busy = 1'b0;
        end
        chk("starve_busy_no_we", {31'd0, stayed_busy}, 32'd1);
        chk("starve_write_count", 64'(wr_addr_q.size() - nwr), 64'd0);
        chk("starve_ovr", {63'd0, ovr}, 64'd1);
        vram_gnt = 1'b1;
        idle(3);
        chk("grant_one_write", 64'(wr_addr_q.size() - nwr), 64'd1);
        chk("grant_result", {busy, ovr, vram_addr, mem[16'h1000]}, {1'b0, 1'b1, 16'h1001, 8'h3C});

        // Address wrap at 0xFFFF
        addr_hi = 2'd3;
        op(1, 1, 8'hFF);
        op(1, 1, 8'h7F);
        chk("wrap_setup", 64'(vram_addr), 64'hFFFF);
        nwr = wr_addr_q.size();
        op(1, 0, 8'h01); idle(1);
        op(1, 0, 8'h02); idle(1);
        chk("wrap_count", 64'(wr_addr_q.size() - nwr), 64'd2);
        chk("wrap_addrs", {wr_addr_q[nwr], wr_addr_q[nwr+1], vram_addr}, {16'hFFFF, 16'h0000, 16'h0001});

        // Control read between control writes resets the byte flip-flop
        addr_hi = 2'd0;
        op(1, 1, 8'h34);
        op(0, 1, 8'h00);
        op(1, 1, 8'h00);
        op(1, 1, 8'h41);
        chk("ff_cleared_by_ctrl_read", {busy, vram_addr, cpu_dout}, {1'b0, 16'h0100, 8'h5A});

        // Reset while waiting for read data
        op(1, 1, 8'h00);
        op(1, 1, 8'h02);
        idle(1);
        chk("in_rd_wait", {busy, vram_re, vram_addr}, {1'b1, 1'b0, 16'h0200});
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("reset_rd_wait", {busy, ovr, vram_we, vram_re, vram_addr, cpu_dout}, {4'b0, 16'h0000, 8'h00});
        idle(1);
        chk("after_reset_idle", {busy, vram_we, vram_re}, 3'b000);
        op(0, 0, 8'h00);
        chk("rd_buf_cleared", 64'(cpu_dout), 64'h00);
        idle(3);
        chk("no_we_re_overlap", 64'(overlap), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vram_cpu_port.md
VRAM_CPU_PORT -- requirements
Module: vram_cpu_port

Interface
REQ-001 SHALL have ports:
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  one-cycle access strobe
- cpu_wr  in  1  1=write, 0=read
- cpu_mode  in  1  0=data port, 1=control port
- cpu_din  in  8  CPU write data
- cpu_dout  out  8  CPU read data
- busy  out  1  access pending, new requests ignored
- ovr  out  1  sticky: request arrived while busy
- addr_hi  in  2  VRAM A15:A14 page, sampled at address setup
- status_in  in  8  status byte for control reads
- status_rd  out  1  one-cycle pulse on a control read
- reg_we  out  1  one-cycle register-write pulse
- reg_addr  out  6  register number
- reg_data  out  8  register value
- vram_gnt  in  1  arbiter grants the CPU slot this cycle
- vram_we  out  1  RAM write enable
- vram_re  out  1  RAM read enable
- vram_addr  out  16  RAM address
- vram_dout  out  8  data to RAM din
- vram_din  in  8  RAM dout, valid one cycle after vram_re

Function
REQ-002 SHALL drive a single-port RAM with 1-cycle registered read latency; SHALL never assert vram_we and vram_re together.
REQ-003 SHALL accept cpu_req only while busy=0; a cpu_req with busy=1 SHALL be dropped and SHALL set ovr until reset.
REQ-004 SHALL contain a control-port byte flip-flop ff, initially 0.
REQ-005 Control write with ff=0: SHALL latch cpu_din into lo_byte and set ff=1.
REQ-006 Control write with ff=1, by cpu_din[7:6], then ff=0:
- 00 read setup: addr={addr_hi,cpu_din[5:0],lo_byte}; enter RD_PEND.
- 01 write setup: load addr the same way; no RAM access.
- 10 register write: pulse reg_we next cycle with reg_addr=cpu_din[5:0] and reg_data=lo_byte.
- 11: no action.
REQ-007 Control read: SHALL set cpu_dout=status_in, pulse status_rd and clear ff, all on the next edge.
REQ-008 Any data-port access SHALL clear ff.
REQ-009 Data write: SHALL load rd_buf and wr_buf with cpu_din and enter WR_PEND.
REQ-010 Data read: SHALL set cpu_dout=rd_buf on the next edge and enter RD_PEND (read-ahead).
REQ-011 FSM states: IDLE, WR_PEND, RD_PEND, RD_WAIT; busy=(state!=IDLE).
REQ-012 WR_PEND: vram_we=vram_gnt (combinational) and vram_dout=wr_buf; on a granted edge go to IDLE with addr=addr+1.
REQ-013 RD_PEND: vram_re=vram_gnt; on a granted edge go to RD_WAIT.
REQ-014 RD_WAIT: rd_buf<=vram_din, addr<=addr+1, go to IDLE; there is no gnt dependence.
REQ-015 vram_addr SHALL equal addr (registered); addr SHALL be 16 bits and wrap from 0xFFFF to 0x0000.
REQ-016 Without vram_gnt, a pending state SHALL hold indefinitely with no RAM strobes.
REQ-017 Latency with gnt always high:
- Write: request edge E; vram_we in cycle E+1; busy low from E+2.
- Read: vram_re in E+1; rd_buf updated at edge E+2; busy low from E+3.

Reset
REQ-018 With reset=1 at an edge, the block SHALL set:
- state=IDLE, ff=0, ovr=0, addr=0, lo_byte=0, rd_buf=0, wr_buf=0
- cpu_dout=0, reg_we=0, status_rd=0, reg_addr=0, reg_data=0
REQ-019 Reset during WR_PEND, RD_PEND or RD_WAIT SHALL abandon the access; no vram_we/vram_re SHALL occur in the cycle after reset.

Structure
REQ-020 Shared package SHALL hold the FSM state encoding, control-code constants (00/01/10/11) and address width (16).
REQ-021 Single module; no sub-modules are required.

Verification
REQ-022 Write setup: ctrl 0x34, ctrl 0x52, addr_hi=0; data write 0xA5 with gnt=1 -> vram_we in one cycle with vram_addr=0x1234, vram_dout=0xA5; addr then 0x1235.
REQ-023 Read-ahead: RAM[0x0100]=0x11, RAM[0x0101]=0x22; ctrl 0x00, ctrl 0x01; first data read -> 0x11, second -> 0x22; vram_re at 0x0100, 0x0101, 0x0102.
REQ-024 Register write: ctrl 0x07, ctrl 0x87 -> single reg_we pulse with reg_addr=7, reg_data=0x07; no RAM strobes.
REQ-025 Grant starvation: gnt=0 for 20 cycles during WR_PEND -> busy stays 1, no vram_we; second cpu_req -> ovr=1; gnt=1 -> exactly one write.
REQ-026 Wrap and ff: write setup to 0xFFFF with addr_hi=3, then two data writes -> addresses 0xFFFF, 0x0000; a control read between two control writes clears ff (next ctrl byte treated as lo_byte).
REQ-027 Reset in RD_WAIT -> state IDLE next cycle, rd_buf=0, busy=0, no RAM strobes.
